audio_pwm_out: RTL and testbench

AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

---
 rtl/audio_pwm_out.sv | 127 ++++++++++++
 tb/tb_audio_pwm_out.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_out.sv
// Audio PWM output stage: an 8-bit sample FIFO feeding a 256-cycle PWM,
// one period per sample, with underrun pulse and saturating underrun count.
module audio_pwm_out #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LVLW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mute,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            pwm_out,
    output logic            sample_tick,
    output logic            underrun,
    output logic [7:0]      underrun_cnt,
    output logic [LVLW-1:0] fifo_level
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = 8;
    localparam int unsigned UCW  = 8;
    localparam logic [CNTW-1:0] CNT_LAST = '1;
    localparam logic [UCW-1:0]  UCNT_MAX = '1;

    logic [7:0]      mem_q [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0] level_q,  level_d;
    logic [CNTW-1:0] cnt_q,    cnt_d;
    logic [7:0]      duty_q,   duty_d;
    logic            pwm_q,    pwm_d;
    logic            tick_q,   tick_d;
    logic            urun_q,   urun_d;
    logic [UCW-1:0]  ucnt_q,   ucnt_d;

    logic full_c;
    logic empty_c;
    logic push_c;
    logic load_c;
    logic pop_c;

    assign full_c   = (level_q == LVLW'(DEPTH));
    assign empty_c  = (level_q == '0);
    assign in_ready = !full_c;
    assign push_c   = in_valid && !full_c;
    // Load happens on the last count of a period; no bypass from the input.
    assign load_c   = en && (cnt_q == CNT_LAST);
    assign pop_c    = load_c && !empty_c;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        duty_d   = duty_q;
        pwm_d    = 1'b0;
        tick_d   = 1'b0;
        urun_d   = 1'b0;
        ucnt_d   = ucnt_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
            duty_d   = mem_q[rd_ptr_q];
        end

        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LVLW'(1);
            2'b01:   level_d = level_q - LVLW'(1);
            default: level_d = level_q;
        endcase

        if (en) begin
            cnt_d = cnt_q + CNTW'(1);
        end

        // Compare uses the pre-increment count so a new duty starts at count 0.
        pwm_d  = en && !mute && (cnt_q < duty_q);
        tick_d = pop_c;
        urun_d = load_c && empty_c;
        if (urun_d && (ucnt_q != UCNT_MAX)) begin
            ucnt_d = ucnt_q + UCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
            tick_q   <= 1'b0;
            urun_q   <= 1'b0;
            ucnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            tick_q   <= tick_d;
            urun_q   <= urun_d;
            ucnt_q   <= ucnt_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign pwm_out      = pwm_q;
    assign sample_tick  = tick_q;
    assign underrun     = urun_q;
    assign underrun_cnt = ucnt_q;
    assign fifo_level   = level_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out: a queue mirrors FIFO contents and each
// 256-cycle period is checked for high count, load/underrun and occupancy.
module tb_audio_pwm_out;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mute;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       pwm_out;
    logic       sample_tick;
    logic       underrun;
    logic [7:0] underrun_cnt;
    logic [2:0] fifo_level;

    int         errors;
    int         checks;
    logic [7:0] sbq[$];
    logic [7:0] cur_duty;
    int         exp_ucnt;
    logic [7:0] fill_vals[4];

    audio_pwm_out #(.DEPTH(4), .LVLW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mute         (mute),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pwm_out      (pwm_out),
        .sample_tick  (sample_tick),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts on the negedge of a cycle where the PWM count is 0; ends on the
    // negedge where the next load result is visible.
    task automatic check_period(input bit ps, input logic [7:0] ds,
                                input bit pl, input logic [7:0] dl, input string tag);
        int highs;
        int avail;
        int exp_h;
        highs = 0;
        avail = 0;
        exp_h = mute ? 0 : int'(cur_duty);
        if (ps) begin
            in_valid = 1'b1;
            in_data  = ds;
            sbq.push_back(ds);
        end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i == 0 && ps) in_valid = 1'b0;
            if (pwm_out === 1'b1) highs++;
            if (i == 254) begin
                avail = sbq.size();
                if (pl) begin
                    in_valid = 1'b1;
                    in_data  = dl;
                    sbq.push_back(dl);
                end
            end
            if (i == 255 && pl) in_valid = 1'b0;
        end
        chk($sformatf("%s highs", tag), 32'(highs), 32'(exp_h));
        if (avail > 0) begin
            cur_duty = sbq.pop_front();
            chk($sformatf("%s tick", tag), 32'(sample_tick), 32'd1);
            chk($sformatf("%s no_urun", tag), 32'(underrun), 32'd0);
        end else begin
            if (exp_ucnt < 255) exp_ucnt++;
            chk($sformatf("%s urun", tag), 32'(underrun), 32'd1);
            chk($sformatf("%s no_tick", tag), 32'(sample_tick), 32'd0);
        end
        chk($sformatf("%s ucnt", tag), 32'(underrun_cnt), 32'(exp_ucnt));
        chk($sformatf("%s level", tag), 32'(fifo_level), 32'(sbq.size()));
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cur_duty  = 8'h00;
        exp_ucnt  = 0;
        rst       = 1'b1;
        en        = 1'b0;
        mute      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        fill_vals = '{8'hFF, 8'h80, 8'h80, 8'h80};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst pwm_out", 32'(pwm_out), 32'd0);
        chk("rst tick", 32'(sample_tick), 32'd0);
        chk("rst urun", 32'(underrun), 32'd0);
        chk("rst ucnt", 32'(underrun_cnt), 32'd0);
        chk("rst level", 32'(fifo_level), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Asynchronous reset mid-period with three samples buffered
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = fill_vals[i];
            sbq.push_back(fill_vals[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        en = 1'b1;
        check_period(1'b0, 8'h00, 1'b0, 8'h00, "rm_p0");
        repeat (10) @(negedge clk);
        chk("rm pre level", 32'(fifo_level), 32'd3);
        chk("rm pre pwm", 32'(pwm_out), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rm pwm_out", 32'(pwm_out), 32'd0);
        chk("rm tick", 32'(sample_tick), 32'd0);
        chk("rm urun", 32'(underrun), 32'd0);
        chk("rm ucnt", 32'(underrun_cnt), 32'd0);
        chk("rm level", 32'(fifo_level), 32'd0);
        chk("rm in_ready", 32'(in_ready), 32'd1);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        cur_duty = 8'h00;
        exp_ucnt = 0;
        @(negedge clk);
        chk("rm post level", 32'(fifo_level), 32'd0);
        chk("rm post pwm", 32'(pwm_out), 32'd0);

        // Fill with en=0, then hold an extra sample against a full FIFO
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i * 16);
            sbq.push_back(8'(i * 16));
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = 8'h50;
        repeat (3) @(negedge clk);
        chk("ovf level", 32'(fifo_level), 32'd4);
        chk("ovf in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Duty periods: 0x40 then 0xFF reach the FIFO behind the fill data
        en = 1'b1;
        check_period(1'b0, 8'h00, 1'b0, 8'h00, "d_p0");
        check_period(1'b1, 8'h40, 1'b0, 8'h00, "d_10");
        check_period(1'b1, 8'hFF, 1'b0, 8'h00, "d_20");
        check_period(1'b0, 8'h00, 1'b0, 8'h00, "d_30");
        check_period(1'b0, 8'h00, 1'b0, 8'h00, "d_40a");
        check_period(1'b0, 8'h00, 1'b0, 8'h00, "d_40b");
        check_period(1'b0, 8'h00, 1'b0, 8'h00, "d_ff");

        // Empty FIFO: duty holds at 0xFF across underruns
        check_period(1'b0, 8'h00, 1'b0, 8'h00, "u_2");
        check_period(1'b0, 8'h00, 1'b0, 8'h00, "u_3");
        chk("u ucnt3", 32'(underrun_cnt), 32'd3);

        // Push in the load cycle at level 1, and into an empty FIFO (no bypass)
        check_period(1'b1, 8'hA0, 1'b1, 8'hB0, "s_p0");
        check_period(1'b0, 8'h00, 1'b1, 8'hC0, "s_a0");
        check_period(1'b0, 8'h00, 1'b0, 8'h00, "s_b0");
        check_period(1'b0, 8'h00, 1'b1, 8'hD0, "s_c0");
        check_period(1'b1, 8'h80, 1'b0, 8'h00, "s_c0h");
        check_period(1'b1, 8'h80, 1'b0, 8'h00, "s_d0");

        // Mute keeps consumption and underrun detection running
        mute = 1'b1;
        check_period(1'b0, 8'h00, 1'b0, 8'h00, "m_80a");
        check_period(1'b0, 8'h00, 1'b0, 8'h00, "m_80b");
        mute = 1'b0;

        // en=0 forces the output low and blocks loads but still accepts pushes
        en       = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h55;
        sbq.push_back(8'h55);
        @(negedge clk);
        in_valid = 1'b0;
        chk("dis pwm", 32'(pwm_out), 32'd0);
        chk("dis level", 32'(fifo_level), 32'd1);
        repeat (300) @(negedge clk);
        chk("dis level hold", 32'(fifo_level), 32'd1);
        chk("dis tick", 32'(sample_tick), 32'd0);
        chk("dis urun", 32'(underrun), 32'd0);
        chk("dis ucnt", 32'(underrun_cnt), 32'(exp_ucnt));
        en = 1'b1;
        check_period(1'b0, 8'h00, 1'b0, 8'h00, "e_80");
        check_period(1'b0, 8'h00, 1'b0, 8'h00, "e_55");

        // Run to 300 underruns in total; the count saturates
        for (int i = 0; i < 294; i++) begin
            check_period(1'b0, 8'h00, 1'b0, 8'h00, $sformatf("sat_%0d", i));
        end
        chk("sat ucnt", 32'(underrun_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
